colour_step_ctrl: RTL and testbench
===================================

# colour_step_ctrl

Upstream control stage for the RGB colour lookup. Turns a raw push-button and an optional auto-advance timer into the 3-bit `colour` address and `enable` strobe that drive the lookup's `colour`/`enable` inputs. Also emits `rgb_update`, a pulse aligned with the lookup's one-cycle registered read, so downstream logic knows when `rgb` holds the new colour.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a button level change is accepted; valid range ≥1.
- `AUTO_PERIOD`, default 8: cycles between automatic steps; valid range ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `button` in 1: raw, asynchronous, bouncy push-button.
- `auto_mode` in 1: level; high enables the periodic step.
- `colour` out 3: lookup address.
- `enable` out 1: one-cycle read strobe to the lookup.
- `rgb_update` out 1: one-cycle pulse, the cycle after `enable`.

## Operation
- Reset values: `colour`=0, `enable`=0, `rgb_update`=0, FSM=INIT, all counters 0, debounced level 0.
- **FSM states**
  - INIT: one cycle after reset release. Asserts `enable` with `colour`=0, so the lookup loads black. Then goes to IDLE.
  - IDLE: `colour`=0. The first step sets `colour`=1 and goes to RUN.
  - RUN: each step does 1→2→3→4→5→6→1. Code 7 is never driven.
- **`enable` rule:** high for exactly the cycle in which `colour` takes a new value, and in the INIT cycle. Low otherwise.
- **`rgb_update`:** `enable` delayed by one register.
- **Button path**
  - 2-flop synchroniser.
  - Debounce counter: cleared whenever the synchronised level equals the debounced level. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised level and the counter clears.
  - A step is generated on a 0→1 transition of the debounced level only. Release never steps, and holding the button gives exactly one step.
- **Auto path**
  - Counter width is $clog2(`AUTO_PERIOD`).
  - Counts while `auto_mode`=1 and the FSM is not INIT. Cleared while `auto_mode`=0.
  - When it reaches `AUTO_PERIOD`-1 it issues a step and wraps to 0.
- **Simultaneous button step and auto step:** exactly one step. The auto counter clears to 0.
- **Any button step clears the auto counter,** so the next auto step comes `AUTO_PERIOD` cycles later.
- **`rst` asserted mid-operation:** all state returns to reset values immediately (asynchronously). A press in progress is discarded.

## Timing
- **Button latency:** `button` high (clean) first sampled at edge k → `colour`/`enable` update at edge k+2+`DEBOUNCE_CYCLES`. `rgb_update` follows at k+3+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** a pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no step.
- **Auto timing:** `auto_mode` high from reset release → first step at edge `AUTO_PERIOD`+1 after release (INIT cycle excluded). Steps then repeat every `AUTO_PERIOD` cycles.
- **Step rate:** at most one step per cycle. `colour` is a registered output with no combinational path from inputs.

## Configuration
- `COLOUR_STEP_AUTO_EN` defined: auto path built as above.
- `COLOUR_STEP_AUTO_EN` undefined:
  - The auto counter is not synthesised.
  - The `auto_mode` port remains but is ignored.
  - Only button steps advance `colour`.

## Structure
- **Package `colour_pkg`:**
  - `colour_t` (logic [2:0]).
  - Constants `COL_BLACK`=0, `COL_FIRST`=1, `COL_LAST`=6.
  - FSM state enum `step_state_t` {INIT, IDLE, RUN}.
- **Sub-module `button_debounce`:**
  - Contents: synchroniser, debounce counter and rising-edge detect.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `button` → `press` (1-cycle pulse).
- **Top:** FSM, auto counter, output registers.

## Test plan
- **Reset release:** release `rst` → `enable`=1 with `colour`=0 for exactly one cycle, `rgb_update`=1 the next cycle, then `colour` holds 0 with `enable`=0.
- **Clean press:** hold `button` high 10 cycles → `colour` 0→1 at edge k+6, single `enable` pulse. Hold 20 more cycles → no further change.
- **Bounce and wrap:** 3-cycle glitch → no step. Seven clean presses from IDLE → `colour` sequence 1,2,3,4,5,6,1; 7 never seen.
- **Auto mode:** `auto_mode`=1 with `COLOUR_STEP_AUTO_EN` defined → `colour` 1 at edge 9 after release, 2 at edge 17. Press coinciding with an auto tick → single step, next auto step 8 cycles later.
- **Reset mid-run:** `colour`=4, assert `rst` for 1 cycle → all outputs 0 immediately, INIT pulse after release.
- **Macro undefined:** `auto_mode`=1 for 100 cycles → `colour` stays 0. Button press → 1.

Source files
------------

// File: rtl/colour_pkg.sv
// Shared types and constants for the colour step controller.
// Colour codes index the RGB lookup; code 7 is reserved and never driven.
package colour_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t COL_BLACK = 3'd0;
    localparam colour_t COL_FIRST = 3'd1;
    localparam colour_t COL_LAST  = 3'd6;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } step_state_t;

    function automatic colour_t next_colour(input colour_t c);
        return (c == COL_LAST) ? COL_FIRST : colour_t'(c + 3'd1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and
// rising-edge detect producing a single-cycle press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level is accepted on the cycle the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= button;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/colour_step_ctrl.sv
// Colour step controller: button/auto steps drive the lookup colour and enable.
// Define COLOUR_STEP_AUTO_EN to build the periodic auto-advance path.
module colour_step_ctrl
    import colour_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       auto_mode,
    output logic [2:0] colour,
    output logic       enable,
    output logic       rgb_update
);

    step_state_t state_q, state_d;
    colour_t     colour_q, colour_d;
    logic        enable_q, enable_d;
    logic        rgb_update_q;
    logic        press;
    logic        step;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (press)
    );

`ifdef COLOUR_STEP_AUTO_EN
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_tick;

    assign auto_tick = auto_mode && (state_q != INIT) && (auto_cnt_q == AUTO_LAST);

    // Any step, auto or button, restarts the period.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (!auto_mode || state_q == INIT) begin
            auto_cnt_d = '0;
        end else if (auto_tick || press) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign step = press | auto_tick;
`else
    logic auto_mode_unused;
    assign auto_mode_unused = auto_mode;
    assign step = press;
`endif

    always_comb begin
        state_d  = state_q;
        colour_d = colour_q;
        enable_d = 1'b0;
        case (state_q)
            INIT: begin
                colour_d = COL_BLACK;
                enable_d = 1'b1;
                state_d  = IDLE;
            end
            IDLE: begin
                if (step) begin
                    colour_d = COL_FIRST;
                    enable_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    colour_d = next_colour(colour_q);
                    enable_d = 1'b1;
                end
            end
            default: begin
                state_d  = INIT;
                colour_d = COL_BLACK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            colour_q     <= COL_BLACK;
            enable_q     <= 1'b0;
            rgb_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            colour_q     <= colour_d;
            enable_q     <= enable_d;
            rgb_update_q <= enable_q;
        end
    end

    assign colour     = colour_q;
    assign enable     = enable_q;
    assign rgb_update = rgb_update_q;

endmodule

// File: tb/tb_colour_step_ctrl.sv
// Directed bench for colour_step_ctrl (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
// The auto-mode section follows whichever way COLOUR_STEP_AUTO_EN is set.
module tb_colour_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       auto_mode = 1'b0;
    logic [2:0] colour;
    logic       enable;
    logic       rgb_update;

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;
    int en_cnt   = 0;
    bit seen7    = 1'b0;

    colour_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .auto_mode  (auto_mode),
        .colour     (colour),
        .enable     (enable),
        .rgb_update (rgb_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        en_cnt += int'(enable);
        if (colour == 3'd7) seen7 = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_to(input int n);
        while (ecnt < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ecnt = 0;
        ticks(3);
    endtask

    task automatic push();
        button = 1'b1;
        ticks(8);
        button = 1'b0;
        ticks(8);
    endtask

    logic [2:0] wrap_exp [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

    initial begin
        // reset state
        ticks(2);
        check("rst_colour", 32'(colour), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_rgbupd", 32'(rgb_update), 0);

        // release: INIT enable pulse, then rgb_update
        rst = 1'b0;
        ecnt = 0;
        tick();
        check("init_enable", 32'(enable), 1);
        check("init_colour", 32'(colour), 0);
        tick();
        check("init_enable_off", 32'(enable), 0);
        check("init_rgbupd", 32'(rgb_update), 1);
        tick();
        check("init_rgbupd_off", 32'(rgb_update), 0);
        check("idle_colour", 32'(colour), 0);

        // clean press: first sampled at edge k, step lands at k+6
        button = 1'b1;
        ticks(6);
        check("press_early", 32'(colour), 0);
        en_cnt = 0;
        tick();
        check("press_colour", 32'(colour), 1);
        check("press_enable", 32'(enable), 1);
        tick();
        check("press_rgbupd", 32'(rgb_update), 1);
        check("press_enable_off", 32'(enable), 0);
        ticks(22);
        check("hold_colour", 32'(colour), 1);
        check("hold_en_cnt", 32'(en_cnt), 1);
        button = 1'b0;
        ticks(12);
        check("release_colour", 32'(colour), 1);
        check("release_en_cnt", 32'(en_cnt), 1);

        // 3-cycle glitch is rejected
        button = 1'b1;
        ticks(3);
        button = 1'b0;
        ticks(12);
        check("glitch_colour", 32'(colour), 1);
        check("glitch_en_cnt", 32'(en_cnt), 1);

        // seven presses from IDLE wrap 6 -> 1
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en_cnt = 0;
            push();
            check($sformatf("wrap_colour%0d", i), 32'(colour), 32'(wrap_exp[i]));
            check($sformatf("wrap_en%0d", i), 32'(en_cnt), 1);
        end
        check("never_seven", 32'(seen7), 0);

        // reset mid-run with a press in progress
        for (int i = 0; i < 3; i++) push();
        check("midrun_colour", 32'(colour), 4);
        button = 1'b1;
        ticks(3);
        rst = 1'b1;
        #2;
        check("async_colour", 32'(colour), 0);
        check("async_enable", 32'(enable), 0);
        check("async_rgbupd", 32'(rgb_update), 0);
        @(posedge clk);
        #1;
        button = 1'b0;
        rst = 1'b0;
        ecnt = 0;
        tick();
        check("rerun_init_enable", 32'(enable), 1);
        check("rerun_init_colour", 32'(colour), 0);
        tick();
        check("rerun_rgbupd", 32'(rgb_update), 1);
        ticks(12);
        check("discard_press", 32'(colour), 0);

`ifdef COLOUR_STEP_AUTO_EN
        // auto steps at edges 9, 17, 25, ... after release
        auto_mode = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ecnt = 0;
        tick_to(8);
        check("auto_pre", 32'(colour), 0);
        tick_to(9);
        check("auto_first", 32'(colour), 1);
        check("auto_first_en", 32'(enable), 1);
        tick_to(16);
        check("auto_hold", 32'(colour), 1);
        tick_to(17);
        check("auto_second", 32'(colour), 2);
        tick_to(25);
        check("auto_third", 32'(colour), 3);
        // press landing on edge 33 together with the auto tick
        tick_to(26);
        button = 1'b1;
        tick_to(32);
        check("coinc_pre", 32'(colour), 3);
        en_cnt = 0;
        tick_to(33);
        check("coinc_colour", 32'(colour), 4);
        tick_to(34);
        button = 1'b0;
        tick_to(40);
        check("coinc_single", 32'(colour), 4);
        check("coinc_en_cnt", 32'(en_cnt), 1);
        tick_to(41);
        check("auto_after_coinc", 32'(colour), 5);
        // press at edge 48 restarts the period: next auto at 56
        button = 1'b1;
        tick_to(48);
        check("btn_step", 32'(colour), 6);
        tick_to(50);
        button = 1'b0;
        tick_to(55);
        check("btn_clears_auto", 32'(colour), 6);
        tick_to(56);
        check("auto_after_btn", 32'(colour), 1);
        auto_mode = 1'b0;
        ticks(20);
        check("auto_off", 32'(colour), 1);
`else
        // auto_mode ignored in this build
        auto_mode = 1'b1;
        do_reset();
        ticks(100);
        check("noauto_colour", 32'(colour), 0);
        push();
        check("noauto_press", 32'(colour), 1);
        auto_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
